// File: rtl/tx_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_pkg
// Purpose  : Shared constants for the parametrised transmit FIFO. Holds the
//            default geometry and flag thresholds, plus a helper that turns
//            an address width into a storage depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tx_fifo_pkg;

  // Default geometry: 8 entries of 8 bits, matching the fixed 8x8 buffer
  // this block replaces.
  localparam int c_DATA_WIDTH = 8;
  localparam int c_ADDR_BITS  = 3;

  // Default thresholds: almost_full at 6 of 8, almost_empty at 2 or fewer.
  localparam int c_AF_LEVEL   = 6;
  localparam int c_AE_LEVEL   = 2;

  // Number of storage entries addressed by an ADDR_BITS-wide pointer.
  function automatic int depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage : tx_fifo_pkg
`default_nettype wire

// File: rtl/tx_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_param_if
// Purpose  : Bundles the producer/consumer handshake and status signals of
//            the transmit FIFO.
// Ports    : master - drives clear, write_enable, write_data, read_enable;
//                     observes read_data, status flags, count, error flags.
//            slave  - the FIFO side (mirror of master).
// Revision : 1.0 - initial release
// ============================================================================
interface tx_fifo_param_if
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_BITS  = c_ADDR_BITS
);

  // Control from the producer / transmitter controller
  logic                  clear;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;

  // Data and status back from the FIFO
  logic [DATA_WIDTH-1:0] read_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear,
    output write_enable,
    output write_data,
    output read_enable,
    input  read_data,
    input  fifo_empty,
    input  fifo_full,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  clear,
    input  write_enable,
    input  write_data,
    input  read_enable,
    output read_data,
    output fifo_empty,
    output fifo_full,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface : tx_fifo_param_if
`default_nettype wire

// File: rtl/tx_fifo_param_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fifo_regfile
// Purpose  : Storage array for the transmit FIFO. One synchronous write port
//            and one asynchronous read port so the head entry is visible
//            without a read cycle (first-word-fall-through).
// Ports    : clk   - write clock
//            wen   - write strobe, sampled on rising edge
//            waddr - write address
//            wdata - write data
//            raddr - read address
//            rdata - contents of entry raddr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_regfile
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_BITS  = c_ADDR_BITS
) (
  input  wire logic                  clk,
  input  wire logic                  wen,
  input  wire logic [ADDR_BITS-1:0]  waddr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  input  wire logic [ADDR_BITS-1:0]  raddr,
  output logic      [DATA_WIDTH-1:0] rdata
);

  localparam int c_DEPTH = depth(ADDR_BITS);

  // No reset on the array: emptiness is tracked by the pointers and count,
  // so stale contents are never presented.
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : fifo_regfile
`default_nettype wire

// File: rtl/tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_param
// Purpose  : Parametrised first-word-fall-through transmit FIFO between the
//            byte producer and the serial transmitter controller. Provides
//            occupancy count, programmable almost-full/almost-empty flags,
//            sticky overflow/underflow flags and a synchronous flush.
// Ports    : clk   - system clock, rising edge
//            n_rst - asynchronous active-low reset
//            bus   - tx_fifo_param_if slave modport:
//                    clear, write_enable, write_data, read_enable (in)
//                    read_data, fifo_empty, fifo_full, almost_full,
//                    almost_empty, count, overflow, underflow (out)
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_param
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_BITS  = c_ADDR_BITS,
  parameter int AF_LEVEL   = c_AF_LEVEL,
  parameter int AE_LEVEL   = c_AE_LEVEL
) (
  input wire logic  clk,
  input wire logic  n_rst,
  tx_fifo_param_if.slave bus
);

  localparam int                    c_DEPTH      = depth(ADDR_BITS);
  localparam logic [ADDR_BITS:0]    c_FULL_COUNT = (ADDR_BITS+1)'(c_DEPTH);
  localparam logic [ADDR_BITS:0]    c_AF_COUNT   = (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0]    c_AE_COUNT   = (ADDR_BITS+1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0]    c_CNT_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0]  c_PTR_ONE    = ADDR_BITS'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_BITS-1:0]  r_wptr;
  logic [ADDR_BITS-1:0]  r_rptr;
  logic [ADDR_BITS:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wen;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_COUNT);

  // A write into a full FIFO is still accepted when a read frees the head
  // slot on the same edge; the new word then lands in the slot at wptr,
  // which equals rptr when full, i.e. the one just vacated.
  assign w_push  = bus.write_enable && (!w_full || bus.read_enable);
  assign w_pop   = bus.read_enable && !w_empty;

  // A flush discards any same-cycle push, so storage is not touched either.
  assign w_wen   = w_push && !bus.clear;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_regfile (
    .clk   (clk),
    .wen   (w_wen),
    .waddr (r_wptr),
    .wdata (bus.write_data),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Pointers, occupancy and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally at 2**ADDR_BITS.
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      // Only a write that is actually dropped counts as overflow.
      if (bus.write_enable && !w_push) begin
        r_overflow <= 1'b1;
      end
      // Any read request against an empty FIFO counts as underflow, even
      // when a same-cycle write is accepted.
      if (bus.read_enable && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state only
  // --------------------------------------------------------------------------
  assign bus.read_data    = w_empty ? '0 : w_rdata;
  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.almost_full  = (r_count >= c_AF_COUNT);
  assign bus.almost_empty = (r_count <= c_AE_COUNT);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule : tx_fifo_param
`default_nettype wire

// File: tb/tb_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fifo_param
// Purpose  : Self-checking bench for tx_fifo_param. A queue-based reference
//            model of the FIFO is updated as stimulus is issued; a separate
//            monitor compares every DUT output against it on each falling
//            edge. A second, wider/deeper instance is exercised directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_param;

  localparam int A_DEPTH = 8;
  localparam int A_AF    = 6;
  localparam int A_AE    = 2;
  localparam int B_DEPTH = 16;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  tx_fifo_param_if #(.DATA_WIDTH(8),  .ADDR_BITS(3)) bus_a ();
  tx_fifo_param_if #(.DATA_WIDTH(16), .ADDR_BITS(4)) bus_b ();

  tx_fifo_param #(
    .DATA_WIDTH (8),
    .ADDR_BITS  (3),
    .AF_LEVEL   (A_AF),
    .AE_LEVEL   (A_AE)
  ) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_a.slave)
  );

  tx_fifo_param #(
    .DATA_WIDTH (16),
    .ADDR_BITS  (4),
    .AF_LEVEL   (12),
    .AE_LEVEL   (3)
  ) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_b.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model for instance A: contents in order, plus sticky flags.
  logic [7:0] model_q [$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update for one clock edge with the inputs currently on bus_a.
  task automatic model_edge();
    int  sz;
    bit  push;
    bit  pop;
    if (bus_a.clear) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      sz   = model_q.size();
      push = bus_a.write_enable && (sz < A_DEPTH || bus_a.read_enable);
      pop  = bus_a.read_enable && (sz > 0);
      if (bus_a.write_enable && !push) m_ovf = 1'b1;
      if (bus_a.read_enable && sz == 0) m_unf = 1'b1;
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(bus_a.write_data);
    end
  endtask

  // Drive A for one cycle; model follows the edge; return 1 ns after it.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    bus_a.write_enable = we;
    bus_a.write_data   = wd;
    bus_a.read_enable  = re;
    bus_a.clear        = clr;
    @(posedge clk);
    if (n_rst) model_edge();
    #1;
    bus_a.write_enable = 1'b0;
    bus_a.read_enable  = 1'b0;
    bus_a.clear        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: compare every output of A against the model away from the edge.
  always @(negedge clk) begin : mon
    int         sz;
    logic [7:0] exp_rd;
    sz     = model_q.size();
    exp_rd = (sz > 0) ? model_q[0] : 8'h00;
    chk("a.read_data",    32'(bus_a.read_data),    32'(exp_rd));
    chk("a.count",        32'(bus_a.count),        32'(sz));
    chk("a.fifo_empty",   32'(bus_a.fifo_empty),   32'(sz == 0));
    chk("a.fifo_full",    32'(bus_a.fifo_full),    32'(sz == A_DEPTH));
    chk("a.almost_full",  32'(bus_a.almost_full),  32'(sz >= A_AF));
    chk("a.almost_empty", 32'(bus_a.almost_empty), 32'(sz <= A_AE));
    chk("a.overflow",     32'(bus_a.overflow),     32'(m_ovf));
    chk("a.underflow",    32'(bus_a.underflow),    32'(m_unf));
  end

  logic [15:0] b_ref [B_DEPTH];
  int          bias_w;
  int          bias_r;

  initial begin
    n_rst              = 1'b0;
    bus_a.clear        = 1'b0;
    bus_a.write_enable = 1'b0;
    bus_a.write_data   = 8'h00;
    bus_a.read_enable  = 1'b0;
    bus_b.clear        = 1'b0;
    bus_b.write_enable = 1'b0;
    bus_b.write_data   = 16'h0000;
    bus_b.read_enable  = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    idle(1);

    // First push shows up at the head straight away.
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    idle(1);

    // Fill with alternating pattern, then one dropped write.
    for (int i = 1; i < 8; i++) step(1'b1, (i % 2) ? 8'hF0 : 8'h0F, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    idle(1);

    // Drain with idle gaps, then read from empty, then flush.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // Simultaneous read and write while empty: push only, underflow set.
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Read + write at full: count holds, new word lands behind the rest.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a.head_after_full_rw", 32'(bus_a.read_data), 32'h0000_00AA);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear with a same-cycle push and pop: both discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    idle(1);

    // Asynchronous reset mid-stream with five entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk("rst.count",        32'(bus_a.count),        32'd0);
    chk("rst.fifo_empty",   32'(bus_a.fifo_empty),   32'd1);
    chk("rst.fifo_full",    32'(bus_a.fifo_full),    32'd0);
    chk("rst.almost_empty", 32'(bus_a.almost_empty), 32'd1);
    chk("rst.almost_full",  32'(bus_a.almost_full),  32'd0);
    chk("rst.read_data",    32'(bus_a.read_data),    32'd0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    idle(1);

    // Randomized traffic with drifting read/write bias to visit full/empty.
    for (int blk = 0; blk < 20; blk++) begin
      bias_w = $urandom_range(20, 80);
      bias_r = $urandom_range(20, 80);
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 99) < bias_w),
             8'($urandom),
             ($urandom_range(0, 99) < bias_r),
             ($urandom_range(0, 99) < 2));
      end
    end

    // Wider, deeper instance: fill all 16 entries and drain in order.
    for (int i = 0; i < B_DEPTH; i++) begin
      b_ref[i]           = 16'($urandom);
      bus_b.write_enable = 1'b1;
      bus_b.write_data   = b_ref[i];
      @(posedge clk);
      #1;
    end
    bus_b.write_enable = 1'b0;
    #1;
    chk("b.fifo_full",   32'(bus_b.fifo_full),   32'd1);
    chk("b.count",       32'(bus_b.count),       32'd16);
    chk("b.almost_full", 32'(bus_b.almost_full), 32'd1);
    for (int i = 0; i < B_DEPTH; i++) begin
      chk($sformatf("b.read_data[%0d]", i), 32'(bus_b.read_data), 32'(b_ref[i]));
      bus_b.read_enable = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_b.read_enable = 1'b0;
    #1;
    chk("b.fifo_empty", 32'(bus_b.fifo_empty), 32'd1);
    chk("b.read_data_empty", 32'(bus_b.read_data), 32'd0);
    chk("b.underflow", 32'(bus_b.underflow), 32'd0);
    chk("b.overflow", 32'(bus_b.overflow), 32'd0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tx_fifo_param
`default_nettype wire

// File: doc/tx_fifo_param.md
# tx_fifo_param

Parametrised, first-word-fall-through transmit FIFO, the next generation of the fixed 8x8 transmit buffer. It sits between the byte producer and the serial transmitter controller. Width and depth are set by parameters. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

## Interface
- DATA_WIDTH, 8, bits per entry
- ADDR_BITS, 3, depth = 2**ADDR_BITS entries (default 8)
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..depth
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..depth-1

Ports:
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties FIFO and clears error flags
- write_enable  in  1  push write_data this edge
- write_data  in  DATA_WIDTH  data to push
- read_enable  in  1  pop head entry this edge
- read_data  out  DATA_WIDTH  head entry (FWFT); 0 when empty
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == depth
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_BITS+1  entries currently stored, 0..depth
- overflow  out  1  sticky: write attempted while full without a same-cycle read
- underflow  out  1  sticky: read attempted while empty

## Operation
- State: storage array of depth x DATA_WIDTH, write pointer wptr and read pointer rptr (each ADDR_BITS wide), and count register (ADDR_BITS+1 wide).
- Pointers wrap modulo depth by natural overflow; no explicit compare.
- Priority per edge: reset > clear > push/pop.
- clear: wptr = rptr = count = 0, overflow = underflow = 0. Storage contents are not cleared. Any push/pop that cycle is discarded and does not set the error flags.
- Push accepted when write_enable && (!fifo_full || read_enable). Accepted push writes mem[wptr] and increments wptr.
- Pop accepted when read_enable && !fifo_empty. Accepted pop increments rptr.
- count: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Full with simultaneous read+write: both accepted, count stays at depth, and the new data lands in the slot just vacated.
- Empty with simultaneous read+write: push accepted, pop rejected, underflow set, count becomes 1.
- Rejected write while full: data dropped, storage unchanged, overflow set.
- Error flags stay set until clear or reset.
- read_data = fifo_empty ? 0 : mem[rptr], combinational from registered state.
- All status flags decode combinationally from count.

## Timing
- Reset (n_rst low, asynchronous): count = 0, pointers = 0, overflow = underflow = 0. Resulting outputs: fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), read_data = 0.
- Reset is honoured mid-transfer. Stored data is lost logically.
- Write latency: data pushed at edge N appears on read_data after edge N if the FIFO was empty. Flags and count update after the same edge.
- Pop: read_data advances to the next entry after the edge where the pop is accepted.
- Inputs sampled only on rising edge. No combinational path from write_enable or read_enable to any output.
- Error flags assert the cycle after the offending edge.

## Structure
- Package tx_fifo_pkg holds the default parameter constants and a depth function returning 2**ADDR_BITS.
- One sub-module, fifo_regfile: the storage array with write port (wen, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count, flag and error logic lives in the top.

## Test plan
- Reset, then push 8'h0F, no read -> read_data = 8'h0F, count = 1, fifo_empty = 0, almost_empty = 1.
- Push 8 alternating 8'h0F/8'hF0 -> fifo_full = 1, almost_full = 1 from the 6th push onward, count = 8. A 9th push alone -> overflow = 1 and contents unchanged.
- From full, 8 pops with idle gaps -> read_data sequence 0F,F0,... in order, then fifo_empty = 1, read_data = 0, overflow still 1, underflow = 0.
- Pop on empty -> underflow = 1. Then clear -> both error flags 0, count = 0.
- At full, one cycle of read_enable + write_enable with 8'hAA -> count stays 8, and after 7 more pops read_data = 8'hAA.
- Assert n_rst low mid-stream with count = 5 -> outputs immediately at reset values. With ADDR_BITS = 4 and DATA_WIDTH = 16, fill 16 entries -> fifo_full = 1 and data returned in order.
